// File: rtl/pfd_counter_pkg.sv
// -----------------------------------------------------------------------------
// pfd_counter_pkg
// Shared definitions for the counter-based phase-frequency detector:
//   - FSM state encodings (legacy-compatible localparam constants)
//   - default lock-detector settings
// Sign convention used throughout: phase_err > 0 means the reference edge
// arrived before the feedback edge (ref leads fb, the NCO must speed up);
// phase_err < 0 means fb leads ref.
// -----------------------------------------------------------------------------
package pfd_counter_pkg;

    // Measurement FSM states
    localparam logic [1:0] IDLE      = 2'd0;  // waiting for the opening edge
    localparam logic [1:0] REF_FIRST = 2'd1;  // ref edge seen, counting until fb edge
    localparam logic [1:0] FB_FIRST  = 2'd2;  // fb edge seen, counting until ref edge

    // Lock-detector defaults
    localparam int LOCK_TOL_DEFAULT   = 4;    // max |phase_err| counted as in-lock
    localparam int LOCK_COUNT_DEFAULT = 16;   // consecutive in-lock strobes to lock

endpackage

// File: rtl/pll_edge_sync.sv
// -----------------------------------------------------------------------------
// pll_edge_sync
// Brings an asynchronous clock-like input into the clk domain and produces a
// one-cycle pulse on each synchronized 0->1 transition. The pulse is
// registered, so total latency from input edge to pulse is SYNC_STAGES+1
// cycles. Runs independently of any enable so that re-enabling the detector
// never sees a stale transition.
// Ports:
//   clk      in  1  sampling clock
//   rst_n    in  1  asynchronous active-low reset (chain cleared to 0)
//   async_i  in  1  asynchronous input
//   rise_o   out 1  one-cycle pulse per synchronized rising edge
// -----------------------------------------------------------------------------
module pll_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise_q;

    // NOTE: sequential state uses non-blocking (<=) assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would collapse
    // the synchronizer chain into a single stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/pfd_counter.sv
// -----------------------------------------------------------------------------
// pfd_counter
// Counter-based digital phase-frequency detector. Measures the rising-edge
// offset between the reference clock and the NCO feedback in sys_clk cycles
// and reports it as a signed phase error with a lock indication.
// Ports:
//   sys_clk    in  1            system clock, all logic on rising edge
//   rst_n      in  1            asynchronous active-low reset
//   enable     in  1            detector enable
//   ref_in     in  1            reference clock (asynchronous)
//   fb_in      in  1            feedback clock from the NCO (asynchronous)
//   phase_err  out CNT_WIDTH+1  signed error, +ve = ref leads fb
//   err_valid  out 1            one-cycle strobe: new phase_err/err_sat
//   err_sat    out 1            phase_err magnitude clipped at MAX (or slip)
//   locked     out 1            lock detector output
// -----------------------------------------------------------------------------
module pfd_counter
    import pfd_counter_pkg::*;
#(
    parameter int CNT_WIDTH   = 16,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_TOL    = LOCK_TOL_DEFAULT,
    parameter int LOCK_COUNT  = LOCK_COUNT_DEFAULT
) (
    input  logic                        sys_clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic                        ref_in,
    input  logic                        fb_in,
    output logic signed [CNT_WIDTH:0]   phase_err,
    output logic                        err_valid,
    output logic                        err_sat,
    output logic                        locked
);

    localparam int                    LCW          = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX      = '1;
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE      = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  TOL          = CNT_WIDTH'(LOCK_TOL);
    localparam logic [LCW-1:0]        LOCK_CNT_MAX = LCW'(LOCK_COUNT);

    // Edge detection: identical latency on both paths keeps relative timing.
    logic ref_rise;
    logic fb_rise;

    pll_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
        .clk     (sys_clk),
        .rst_n   (rst_n),
        .async_i (ref_in),
        .rise_o  (ref_rise)
    );

    pll_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_fb_sync (
        .clk     (sys_clk),
        .rst_n   (rst_n),
        .async_i (fb_in),
        .rise_o  (fb_rise)
    );

    // State and output registers
    logic [1:0]                state_q,     state_d;
    logic [CNT_WIDTH-1:0]      cnt_q,       cnt_d;
    logic signed [CNT_WIDTH:0] phase_err_q, phase_err_d;
    logic                      err_sat_q,   err_sat_d;
    logic                      err_valid_q, err_valid_d;
    logic [LCW-1:0]            lock_cnt_q,  lock_cnt_d;
    logic                      locked_q,    locked_d;

    // Measurement emitted this cycle (magnitude + sign)
    logic                      emit;
    logic [CNT_WIDTH-1:0]      emit_mag;
    logic                      emit_neg;
    logic [CNT_WIDTH-1:0]      cnt_inc;
    logic                      in_tol;

    // NOTE: every variable assigned in this block gets a default first, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        emit     = 1'b0;
        emit_mag = '0;
        emit_neg = 1'b0;
        cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

        if (!enable) begin
            // Any partial measurement is discarded.
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ref_rise && fb_rise) begin
                        emit = 1'b1;  // coincident edges: zero error
                    end else if (ref_rise) begin
                        state_d = REF_FIRST;
                        cnt_d   = CNT_ONE;
                    end else if (fb_rise) begin
                        state_d = FB_FIRST;
                        cnt_d   = CNT_ONE;
                    end
                end
                REF_FIRST: begin
                    if (fb_rise) begin
                        emit     = 1'b1;
                        emit_mag = cnt_q;
                        // A coincident ref edge opens the next measurement.
                        state_d  = ref_rise ? REF_FIRST : IDLE;
                        cnt_d    = ref_rise ? CNT_ONE : '0;
                    end else if (ref_rise) begin
                        // Cycle slip: fb missed a whole ref period.
                        emit     = 1'b1;
                        emit_mag = CNT_MAX;
                        cnt_d    = CNT_ONE;
                    end else begin
                        cnt_d    = cnt_inc;
                    end
                end
                FB_FIRST: begin
                    if (ref_rise) begin
                        emit     = 1'b1;
                        emit_neg = 1'b1;
                        emit_mag = cnt_q;
                        state_d  = fb_rise ? FB_FIRST : IDLE;
                        cnt_d    = fb_rise ? CNT_ONE : '0;
                    end else if (fb_rise) begin
                        emit     = 1'b1;
                        emit_neg = 1'b1;
                        emit_mag = CNT_MAX;
                        cnt_d    = CNT_ONE;
                    end else begin
                        cnt_d    = cnt_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output and lock-detector next state
    always_comb begin
        phase_err_d = phase_err_q;
        err_sat_d   = err_sat_q;
        err_valid_d = emit;
        lock_cnt_d  = lock_cnt_q;
        locked_d    = locked_q;
        in_tol      = (emit_mag <= TOL) && (emit_mag != CNT_MAX);

        if (emit) begin
            phase_err_d = emit_neg ? -$signed({1'b0, emit_mag}) : $signed({1'b0, emit_mag});
            err_sat_d   = (emit_mag == CNT_MAX);
        end

        if (!enable) begin
            lock_cnt_d = '0;
            locked_d   = 1'b0;
        end else if (emit) begin
            if (in_tol) begin
                lock_cnt_d = (lock_cnt_q == LOCK_CNT_MAX) ? lock_cnt_q : lock_cnt_q + 1'b1;
                locked_d   = (lock_cnt_d == LOCK_CNT_MAX);
            end else begin
                // A bad measurement drops lock in the same cycle as its strobe.
                lock_cnt_d = '0;
                locked_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            phase_err_q <= '0;
            err_sat_q   <= 1'b0;
            err_valid_q <= 1'b0;
            lock_cnt_q  <= '0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phase_err_q <= phase_err_d;
            err_sat_q   <= err_sat_d;
            err_valid_q <= err_valid_d;
            lock_cnt_q  <= lock_cnt_d;
            locked_q    <= locked_d;
        end
    end

    assign phase_err = phase_err_q;
    assign err_valid = err_valid_q;
    assign err_sat   = err_sat_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_pfd_counter.sv
// -----------------------------------------------------------------------------
// tb_pfd_counter
// Self-checking bench for pfd_counter. Each 100-cycle window (1 MHz at a
// 100 MHz sys_clk) carries one ref rising edge at cycle A and one fb rising
// edge at cycle A+off; the reference model predicts the strobe from the edge
// offset alone and tracks the lock run-length arithmetically. A second
// instance with CNT_WIDTH=4 is used for the saturation/cycle-slip case.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pfd_counter;

    localparam int CW       = 16;
    localparam int W4       = 4;
    localparam int A        = 30;   // ref edge position inside a window
    localparam int HIGH     = 40;   // high time of each pulse
    localparam int TOL      = 4;
    localparam int LOCK_N   = 16;
    localparam int MAX4     = 15;

    logic sys_clk = 1'b0;
    logic rst_n   = 1'b0;
    logic enable  = 1'b0;
    logic ref_in  = 1'b0;
    logic fb_in   = 1'b0;
    logic ref4    = 1'b0;
    logic fb4     = 1'b0;

    logic signed [CW:0] phase_err;
    logic               err_valid, err_sat, locked;
    logic signed [W4:0] phase_err4;
    logic               err_valid4, err_sat4, locked4;

    always #5 sys_clk = ~sys_clk;

    pfd_counter #(.CNT_WIDTH(CW), .SYNC_STAGES(2), .LOCK_TOL(TOL), .LOCK_COUNT(LOCK_N)) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .ref_in    (ref_in),
        .fb_in     (fb_in),
        .phase_err (phase_err),
        .err_valid (err_valid),
        .err_sat   (err_sat),
        .locked    (locked)
    );

    pfd_counter #(.CNT_WIDTH(W4), .SYNC_STAGES(2), .LOCK_TOL(TOL), .LOCK_COUNT(LOCK_N)) dut_w4 (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .ref_in    (ref4),
        .fb_in     (fb4),
        .phase_err (phase_err4),
        .err_valid (err_valid4),
        .err_sat   (err_sat4),
        .locked    (locked4)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Strobes captured away from the active edge
    int got_val[$];
    int got_sat[$];
    int got4_val[$];
    int got4_sat[$];

    always @(negedge sys_clk) begin
        if (err_valid) begin
            got_val.push_back(int'(phase_err));
            got_sat.push_back(int'(err_sat));
        end
        if (err_valid4) begin
            got4_val.push_back(int'(phase_err4));
            got4_sat.push_back(int'(err_sat4));
        end
    end

    // Reference model: last reported error and lock run-length
    int m_last = 0;
    int m_sat  = 0;
    int m_lk   = 0;

    function automatic void model_strobe(int v, int s);
        m_last = v;
        m_sat  = s;
        if (v <= TOL && v >= -TOL && s == 0)
            m_lk = (m_lk < LOCK_N) ? m_lk + 1 : LOCK_N;
        else
            m_lk = 0;
    endfunction

    function automatic int exp_locked();
        return (m_lk >= LOCK_N) ? 1 : 0;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One 100-cycle window. kill>=0 drops enable (mode 0) or asserts rst_n
    // (mode 1) at that cycle and restores it at cycle 90, after both inputs fall.
    task automatic run_window(input int off, input int kill, input int mode);
        for (int c = 0; c < 100; c++) begin
            @(negedge sys_clk);
            ref_in = (c >= A && c < A + HIGH);
            fb_in  = (c >= A + off && c < A + off + HIGH);
            if (kill >= 0 && c == kill) begin
                if (mode == 1) rst_n = 1'b0;
                else           enable = 1'b0;
            end
            if (kill >= 0 && c == 90) begin
                rst_n  = 1'b1;
                enable = 1'b1;
            end
        end
    endtask

    task automatic pair(input string tag, input int off);
        got_val.delete();
        got_sat.delete();
        run_window(off, -1, 0);
        model_strobe(off, 0);
        check({tag, "_count"}, got_val.size(), 1);
        if (got_val.size() > 0) begin
            check({tag, "_err"}, got_val[0], off);
            check({tag, "_sat"}, got_sat[0], 0);
        end
        check({tag, "_hold"}, int'(phase_err), m_last);
        check({tag, "_locked"}, int'(locked), exp_locked());
    endtask

    task automatic killed_pair(input string tag, input int mode);
        got_val.delete();
        got_sat.delete();
        run_window(10, 36, mode);
        m_lk = 0;
        if (mode == 1) begin
            m_last = 0;
            m_sat  = 0;
        end
        check({tag, "_count"}, got_val.size(), 0);
        check({tag, "_err"}, int'(phase_err), m_last);
        check({tag, "_sat"}, int'(err_sat), m_sat);
        check({tag, "_locked"}, int'(locked), 0);
    endtask

    initial begin
        int off;

        // Reset state
        repeat (4) @(negedge sys_clk);
        check("rst_err",    int'(phase_err), 0);
        check("rst_valid",  int'(err_valid), 0);
        check("rst_sat",    int'(err_sat),   0);
        check("rst_locked", int'(locked),    0);
        rst_n  = 1'b1;
        enable = 1'b1;
        repeat (4) @(negedge sys_clk);

        // In-phase clocks: zero error, lock on the 16th strobe
        for (int i = 0; i < LOCK_N; i++) pair("inphase", 0);

        // One bad pair drops lock, then 16 good random pairs re-lock
        pair("bad9", 9);
        for (int i = 0; i < LOCK_N; i++) begin
            off = int'($urandom_range(0, 2 * TOL)) - TOL;
            pair("relock", off);
        end

        // Directed offsets
        pair("fb_late7", 7);
        pair("fb_early12", -12);

        // Random offsets in both directions
        for (int i = 0; i < 8; i++) begin
            off = int'($urandom_range(0, 50)) - 25;
            pair("rand", off);
        end

        // Measurement interrupted by enable, then by reset
        pair("pre_kill", 3);
        killed_pair("en_kill", 0);
        pair("after_en", 5);
        killed_pair("rst_kill", 1);
        pair("after_rst", -6);

        // Narrow counter, ref only: each ref edge after the first is a slip
        got4_val.delete();
        got4_sat.delete();
        for (int w = 0; w < 4; w++) begin
            for (int c = 0; c < 100; c++) begin
                @(negedge sys_clk);
                ref4 = (c >= A && c < A + HIGH);
            end
        end
        check("slip_count", got4_val.size(), 3);
        for (int i = 0; i < got4_val.size(); i++) begin
            check("slip_err", got4_val[i], MAX4);
            check("slip_sat", got4_sat[i], 1);
        end
        check("slip_locked", int'(locked4), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
